// File: rtl/mac_mul_seq.sv
// Job sequencer for the MAC multiply block: streams operand beats into the
// multiplier's registered operand ports and accumulates its products into a wide sum.
module mac_mul_seq #(
    parameter int MAC_CONF_WIDTH = 2,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_INT_WIDTH  = 40,
    parameter int ACC_WIDTH      = 48,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [MAC_CONF_WIDTH-1:0]  cfg_in,
    input  logic [LEN_WIDTH-1:0]       len,
    output logic                       busy,
    output logic                       err,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4*MAC_MIN_WIDTH-1:0] in_a,
    input  logic [MAC_MIN_WIDTH-1:0]   in_b,
    output logic                       mul_en,
    output logic [MAC_CONF_WIDTH-1:0]  mul_cfg,
    output logic [MAC_MIN_WIDTH-1:0]   mul_A0,
    output logic [MAC_MIN_WIDTH-1:0]   mul_A1,
    output logic [MAC_MIN_WIDTH-1:0]   mul_A2,
    output logic [MAC_MIN_WIDTH-1:0]   mul_A3,
    output logic [MAC_MIN_WIDTH-1:0]   mul_B1,
    input  logic [MAC_INT_WIDTH-1:0]   mul_C,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_WIDTH-1:0]       out_acc,
    output logic [1:0]                 dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [MAC_CONF_WIDTH-1:0] CFG_QUAD    = MAC_CONF_WIDTH'(2);
    localparam logic [MAC_CONF_WIDTH-1:0] CFG_ILLEGAL = MAC_CONF_WIDTH'(3);

    // Valid/ready: a beat transfers on an edge where in_valid && in_ready; the result
    // transfers on an edge where out_valid && out_ready. Both ready/valid outputs are
    // pure functions of the state register, so they never depend on the partner's inputs.

    logic [1:0]                 state_q, state_d;
    logic [LEN_WIDTH-1:0]       remaining_q, remaining_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic [MAC_CONF_WIDTH-1:0]  cfg_q, cfg_d;
    logic [4*MAC_MIN_WIDTH-1:0] a_q, a_d;
    logic [MAC_MIN_WIDTH-1:0]   b_q, b_d;
    logic                       mul_en_q, mul_en_d;
    logic                       err_q, err_d;
    logic [ACC_WIDTH-1:0]       ext_c;

    // Quad products are signed; single and dual products are unsigned.
    always_comb begin
        ext_c = '0;
        ext_c[MAC_INT_WIDTH-1:0] = mul_C;
        if (cfg_q == CFG_QUAD && mul_C[MAC_INT_WIDTH-1]) begin
            for (int i = MAC_INT_WIDTH; i < ACC_WIDTH; i++) begin
                ext_c[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        cfg_d       = cfg_q;
        a_d         = a_q;
        b_d         = b_q;
        mul_en_d    = 1'b0;
        err_d       = 1'b0;

        if (mul_en_q) begin
            acc_d = acc_q + ext_c;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_in == CFG_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        cfg_d       = cfg_in;
                        remaining_d = len;
                        acc_d       = '0;
                        state_d     = (len == '0) ? S_DONE : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    a_d         = in_a;
                    b_d         = in_b;
                    mul_en_d    = 1'b1;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            // The last beat's product is added on the edge that leaves DRAIN.
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            cfg_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mul_en_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            cfg_q       <= cfg_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mul_en_q    <= mul_en_d;
            err_q       <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign err       = err_q;
    assign mul_en    = mul_en_q;
    assign mul_cfg   = cfg_q;
    assign mul_A0    = a_q[0*MAC_MIN_WIDTH +: MAC_MIN_WIDTH];
    assign mul_A1    = a_q[1*MAC_MIN_WIDTH +: MAC_MIN_WIDTH];
    assign mul_A2    = a_q[2*MAC_MIN_WIDTH +: MAC_MIN_WIDTH];
    assign mul_A3    = a_q[3*MAC_MIN_WIDTH +: MAC_MIN_WIDTH];
    assign mul_B1    = b_q;
    assign out_acc   = acc_q;
    assign dbg_state = state_q;

endmodule
